csi_tx_clk_lane: RTL

CSI_TX_CLK_LANE -- requirements
Module: csi_tx_clk_lane

---
 rtl/csi_tx_clk_lane.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/csi_tx_clk_lane.sv
// MIPI CSI-2 D-PHY clock lane transmit sequencer (LP/HS entry, exit, ULPS).
// Optional ULPS path is enabled by defining CSI_TX_CLK_ULPS_EN.
module csi_tx_clk_lane #(
  parameter int T_LPX     = 4,
  parameter int T_PREP    = 3,
  parameter int T_ZERO    = 20,
  parameter int T_PRE     = 8,
  parameter int T_POST    = 12,
  parameter int T_TRAIL   = 5,
  parameter int T_HS_EXIT = 6,
  parameter int T_WAKEUP  = 16
) (
  input  logic ref_clock,
  input  logic reset_in_demet,
  input  logic hs_req,
  input  logic ulps_req,
  output logic lp_p,
  output logic lp_n,
  output logic hs_oe,
  output logic hs_clk_en,
  output logic hs_ready,
  output logic stop_state,
  output logic ulps_active
);

  typedef enum logic [3:0] {
    ST_STOP      = 4'd0,
    ST_HS_RQST   = 4'd1,
    ST_HS_PREP   = 4'd2,
    ST_HS_ZERO   = 4'd3,
    ST_HS_CLK    = 4'd4,
    ST_HS_POST   = 4'd5,
    ST_HS_TRAIL  = 4'd6,
    ST_HS_EXIT   = 4'd7
`ifdef CSI_TX_CLK_ULPS_EN
    ,
    ST_ULPS_RQST = 4'd8,
    ST_ULPS      = 4'd9,
    ST_ULPS_EXIT = 4'd10
`endif
  } state_t;

  localparam logic [7:0] LD_LPX   = 8'(T_LPX - 1);
  localparam logic [7:0] LD_PREP  = 8'(T_PREP - 1);
  localparam logic [7:0] LD_ZERO  = 8'(T_ZERO - 1);
  localparam logic [7:0] LD_PRE   = 8'(T_PRE - 1);
  localparam logic [7:0] LD_POST  = 8'(T_POST - 1);
  localparam logic [7:0] LD_TRAIL = 8'(T_TRAIL - 1);
  localparam logic [7:0] LD_EXIT  = 8'(T_HS_EXIT - 1);
`ifdef CSI_TX_CLK_ULPS_EN
  localparam logic [7:0] LD_WAKE  = 8'(T_WAKEUP - 1);
`endif

  state_t     state;
  state_t     state_n;
  logic [7:0] timer;
  logic [7:0] timer_n;
  logic       tmr_zero;

  logic lp_p_n;
  logic lp_n_n;
  logic hs_oe_n;
  logic clk_en_n;
  logic ready_n;
  logic stop_n;

  assign tmr_zero = (timer == 8'd0);

  // Next state and timer; the timer reloads on every state entry.
  always_comb begin
    state_n = state;
    timer_n = tmr_zero ? 8'd0 : timer - 8'd1;
    unique case (state)
      ST_STOP: begin
        if (hs_req) begin
          state_n = ST_HS_RQST;
          timer_n = LD_LPX;
        end
`ifdef CSI_TX_CLK_ULPS_EN
        else if (ulps_req) begin
          state_n = ST_ULPS_RQST;
          timer_n = LD_LPX;
        end
`endif
      end
      ST_HS_RQST: begin
        if (tmr_zero) begin
          state_n = ST_HS_PREP;
          timer_n = LD_PREP;
        end
      end
      ST_HS_PREP: begin
        if (tmr_zero) begin
          state_n = ST_HS_ZERO;
          timer_n = LD_ZERO;
        end
      end
      ST_HS_ZERO: begin
        if (tmr_zero) begin
          state_n = ST_HS_CLK;
          timer_n = LD_PRE;
        end
      end
      ST_HS_CLK: begin
        // Release only counts once the pre-toggle window has elapsed.
        if (tmr_zero && !hs_req) begin
          state_n = ST_HS_POST;
          timer_n = LD_POST;
        end
      end
      ST_HS_POST: begin
        if (tmr_zero) begin
          state_n = ST_HS_TRAIL;
          timer_n = LD_TRAIL;
        end
      end
      ST_HS_TRAIL: begin
        if (tmr_zero) begin
          state_n = ST_HS_EXIT;
          timer_n = LD_EXIT;
        end
      end
      ST_HS_EXIT: begin
        if (tmr_zero) begin
          state_n = ST_STOP;
          timer_n = 8'd0;
        end
      end
`ifdef CSI_TX_CLK_ULPS_EN
      ST_ULPS_RQST: begin
        if (tmr_zero) begin
          state_n = ST_ULPS;
          timer_n = 8'd0;
        end
      end
      ST_ULPS: begin
        if (!ulps_req) begin
          state_n = ST_ULPS_EXIT;
          timer_n = LD_WAKE;
        end
      end
      ST_ULPS_EXIT: begin
        if (tmr_zero) begin
          state_n = ST_STOP;
          timer_n = 8'd0;
        end
      end
`endif
      default: begin
        state_n = ST_STOP;
        timer_n = 8'd0;
      end
    endcase
  end

  // Outputs decoded from the next state so they register with it.
  always_comb begin
    lp_p_n   = 1'b0;
    lp_n_n   = 1'b0;
    hs_oe_n  = 1'b0;
    clk_en_n = 1'b0;
    stop_n   = 1'b0;
    unique case (state_n)
      ST_STOP: begin
        lp_p_n = 1'b1;
        lp_n_n = 1'b1;
        stop_n = 1'b1;
      end
      ST_HS_RQST: begin
        lp_n_n = 1'b1;
      end
      ST_HS_PREP: begin
        lp_p_n = 1'b0;
      end
      ST_HS_ZERO: begin
        hs_oe_n = 1'b1;
      end
      ST_HS_CLK: begin
        hs_oe_n  = 1'b1;
        clk_en_n = 1'b1;
      end
      ST_HS_POST: begin
        hs_oe_n  = 1'b1;
        clk_en_n = 1'b1;
      end
      ST_HS_TRAIL: begin
        hs_oe_n = 1'b1;
      end
      ST_HS_EXIT: begin
        lp_p_n = 1'b1;
        lp_n_n = 1'b1;
      end
`ifdef CSI_TX_CLK_ULPS_EN
      ST_ULPS_RQST: begin
        lp_p_n = 1'b1;
      end
      ST_ULPS: begin
        lp_p_n = 1'b0;
      end
      ST_ULPS_EXIT: begin
        lp_p_n = 1'b1;
      end
`endif
      default: begin
        lp_p_n = 1'b1;
        lp_n_n = 1'b1;
        stop_n = 1'b1;
      end
    endcase
  end

  assign ready_n = (state == ST_HS_CLK) && (state_n == ST_HS_CLK)
                && tmr_zero && hs_req;

  always_ff @(posedge ref_clock or posedge reset_in_demet) begin
    if (reset_in_demet) begin
      state      <= ST_STOP;
      timer      <= 8'd0;
      lp_p       <= 1'b1;
      lp_n       <= 1'b1;
      hs_oe      <= 1'b0;
      hs_clk_en  <= 1'b0;
      hs_ready   <= 1'b0;
      stop_state <= 1'b1;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      lp_p       <= lp_p_n;
      lp_n       <= lp_n_n;
      hs_oe      <= hs_oe_n;
      hs_clk_en  <= clk_en_n;
      hs_ready   <= ready_n;
      stop_state <= stop_n;
    end
  end

`ifdef CSI_TX_CLK_ULPS_EN
  always_ff @(posedge ref_clock or posedge reset_in_demet) begin
    if (reset_in_demet) begin
      ulps_active <= 1'b0;
    end else begin
      ulps_active <= (state_n == ST_ULPS);
    end
  end
`else
  logic ulps_unused;
  assign ulps_unused = ulps_req;
  assign ulps_active = 1'b0;
`endif

endmodule
